// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
//   Four-requester round-robin arbiter that owns a single registered output
//   bus. The current owner's data is forwarded to y one cycle after its grant
//   is visible on gnt. When an owner drops req, the grant moves straight to
//   the next round-robin requester with no idle cycle in between.
//
//   Optional feature (macro ARB_BURST_LIMIT_EN): an owner may hold the bus for
//   at most MAX_BURST consecutive valid cycles while another requester is
//   waiting. Without the macro, an owner keeps the bus until it drops req.
//
// Parameters
//   DW        data width of each requester and of y
//   MAX_BURST valid cycles per ownership when burst limiting is built (1..16)
// Ports
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   req      per-requester request, bit i = requester i
//   din      requester i data on din[i*DW +: DW]
//   gnt      registered one-hot grant (all-zero when idle)
//   y        registered shared output bus
//   y_valid  y holds owner data this cycle
module shared_bus_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [DW-1:0]   y,
  output logic            y_valid
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  // last doubles as the current owner while in GRANT
  logic [1:0]      last, last_n;
  logic [3:0]      gnt_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   y_n;
  logic            yv_n;

  logic [3:0][DW-1:0] lanes;
  logic [3:0]         others;
  logic [1:0]         pick;

  assign lanes = din;

  // First set bit of r, scanning base, base+1, ... with 2-bit wrap.
  // Scanning from the far end lets the nearest match overwrite earlier ones.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Masking with gnt removes the current owner from the search; in IDLE gnt is
  // zero so this is just req.
  always_comb begin
    others = req & ~gnt;
    pick   = rr_pick(others, last + 2'd1);
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    gnt_n   = gnt;
    cnt_n   = cnt;
    y_n     = y;
    yv_n    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          last_n  = pick;
          gnt_n   = 4'b0001 << pick;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (req[last]) begin
          y_n  = lanes[last];
          yv_n = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
          // This edge completes the MAX_BURST-th valid cycle: hand off if
          // anyone is waiting, otherwise start a fresh burst for the owner.
          if (cnt == CW'(MAX_BURST - 1)) begin
            cnt_n = '0;
            if (|others) begin
              last_n = pick;
              gnt_n  = 4'b0001 << pick;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
`else
          // Counting saturates; it has no influence on arbitration here.
          if (cnt != CW'(MAX_BURST)) cnt_n = cnt + CW'(1);
`endif
        end else if (|others) begin
          last_n = pick;
          gnt_n  = 4'b0001 << pick;
          cnt_n  = '0;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // last resets to 3 so that requester 0 wins the first arbitration
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      last    <= 2'd3;
      gnt     <= '0;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      gnt     <= gnt_n;
      cnt     <= cnt_n;
      y       <= y_n;
      y_valid <= yv_n;
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Scoreboard bench for shared_bus_arbiter: the driver applies stimulus, steps
// a rule-level reference model at every rising edge and queues the expected
// outputs; a negedge monitor pops and compares.
module tb_shared_bus_arbiter;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [DW-1:0]   y;
  logic            y_valid;

  shared_bus_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req(req), .din(din),
    .gnt(gnt), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    g;
    logic [DW-1:0] y;
    logic          v;
  } exp_t;

  exp_t sbq[$];
  int   olog[$];
  logic [3:0] prev_g = '0;
  int   errors = 0;
  int   checks = 0;

  // reference model state: owner -1 means nobody holds the bus
  int            m_owner, m_last, m_burst, m_vowner;
  logic [DW-1:0] m_y;
  logic          m_v;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int next_rr(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++)
      if (mask[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_burst = 0; m_y = '0; m_v = 1'b0; m_vowner = -1;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [4*DW-1:0] d);
    logic [3:0] oth;
    m_v = 1'b0;
    m_vowner = -1;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = next_rr(r, m_last); m_last = m_owner; m_burst = 0;
      end
    end else if (r[m_owner]) begin
      m_y = d[m_owner*DW +: DW];
      m_v = 1'b1;
      m_vowner = m_owner;
      m_burst++;
`ifdef ARB_BURST_LIMIT_EN
      if (m_burst == MB) begin
        m_burst = 0;
        oth = r;
        oth[m_owner] = 1'b0;
        if (oth != 0) begin
          m_owner = next_rr(oth, m_owner); m_last = m_owner;
        end
      end
`endif
    end else if (r != 0) begin
      m_owner = next_rr(r, m_owner); m_last = m_owner; m_burst = 0;
    end else begin
      m_owner = -1; m_burst = 0;
    end
    oth = '0;
  endtask

  task automatic step(input logic [3:0] r, input logic [4*DW-1:0] d);
    exp_t e;
    req = r;
    din = d;
    @(posedge clk);
    model_edge(r, d);
    e.g = (m_owner < 0) ? 4'b0000 : 4'(4'b0001 << m_owner);
    e.y = m_y;
    e.v = m_v;
    sbq.push_back(e);
    #1;
  endtask

  // Reset pulse strictly between edges, called right after step().
  task automatic mid_reset();
    #5;
    rstn = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_y", 32'(y), 32'h0);
    check("async_rst_yv", 32'(y_valid), 32'h0);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rnd_din();
    return $urandom;
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("gnt", 32'(gnt), 32'(e.g));
      check("y", 32'(y), 32'(e.y));
      check("y_valid", 32'(y_valid), 32'(e.v));
      check("onehot", 32'($onehot0(gnt)), 32'h1);
    end
    if (gnt != 0 && gnt != prev_g)
      for (int i = 0; i < 4; i++) if (gnt[i]) olog.push_back(i);
    prev_g = gnt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc[4];
    logic [3:0] r;
    rstn = 1'b0; req = '0; din = '0;
    model_reset();
    #3;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_y", 32'(y), 32'h0);
    check("reset_yv", 32'(y_valid), 32'h0);
    #4 rstn = 1'b1;

    // single requester: grant after edge 1, data after edge 2
    step(4'b0001, {24'h0, 8'h11});
    step(4'b0001, {24'h0, 8'h11});
    step(4'b0000, '0);
    step(4'b0000, '0);

    // all request, each leaves after 2 valid cycles
    mid_reset();
    olog.delete();
    vc = '{0, 0, 0, 0};
    for (int n = 0; n < 20; n++) begin
      r = '0;
      for (int i = 0; i < 4; i++) r[i] = (vc[i] < 2);
      step(r, rnd_din());
      if (m_vowner >= 0) vc[m_vowner]++;
      if (r == 0) break;
    end
    @(negedge clk); #1;
    check("rr_order_len", 32'(olog.size()), 32'd4);
    for (int i = 0; i < 4 && i < olog.size(); i++) check("rr_order", 32'(olog[i]), 32'(i));

    // wrap-around 2 -> 3 -> 0
    mid_reset();
    olog.delete();
    step(4'b0100, rnd_din());
    step(4'b1101, rnd_din());
    step(4'b1101, rnd_din());
    step(4'b1001, rnd_din());
    step(4'b1001, rnd_din());
    step(4'b0001, rnd_din());
    step(4'b0001, rnd_din());
    step(4'b0000, rnd_din());
    @(negedge clk); #1;
    check("wrap_len", 32'(olog.size()), 32'd3);
    if (olog.size() == 3) begin
      check("wrap_0", 32'(olog[0]), 32'd2);
      check("wrap_1", 32'(olog[1]), 32'd3);
      check("wrap_2", 32'(olog[2]), 32'd0);
    end

    // two constant requesters: burst limit alternation or indefinite hold
    mid_reset();
    olog.delete();
    for (int n = 0; n < 24; n++) step(4'b0011, rnd_din());
    @(negedge clk); #1;
`ifdef ARB_BURST_LIMIT_EN
    check("burst_owner_changes", 32'(olog.size()), 32'd6);
`else
    check("burst_owner_changes", 32'(olog.size()), 32'd1);
`endif

    // reset during owner 1 burst, then owner 1 regranted on first edge
    mid_reset();
    for (int n = 0; n < 4; n++) step(4'b0010, rnd_din());
    mid_reset();
    for (int n = 0; n < 3; n++) step(4'b0010, rnd_din());

    // randomized traffic with occasional reset pulses
    r = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      step(r, rnd_din());
      if ($urandom_range(99) == 0) mid_reset();
    end
    step(4'b0000, '0);

    for (int n = 0; n < 5 && sbq.size() > 0; n++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
